regfile_bist: RTL and testbench

//   Synthesizable, clocked self-test engine for a 1-write/2-read register file.
//   It replaces the hand-written directed regfile bench with a reusable tester.
//   It drives the DUT write/read ports and walks a 6-phase march over every address.
//   It flags first failure by phase, address and port, so one bench instance covers

---
 rtl/regfile_bist.sv | 191 +++++++++++++++++++
 tb/tb_regfile_bist.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_bist.sv
// March-style self-test engine for a 1-write/2-read register file.
// Walks six phases over every address and latches the first failing phase/address/port.
`timescale 1ns/1ps
module regfile_bist #(
    parameter int          WIDTH    = 32,
    parameter int          ADDR_W   = 5,
    parameter logic [31:0] SEED     = 32'hA5A55A5A,
    parameter int          ZERO_REG = 1
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Start,
    output logic              Busy,
    output logic              Done,
    output logic              Passed,
    output logic [2:0]        FailPhase,
    output logic [ADDR_W-1:0] FailAddr,
    output logic [1:0]        FailPort,
    output logic [WIDTH-1:0]  WriteData,
    output logic [ADDR_W-1:0] WriteRegister,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] ReadRegister1,
    output logic [ADDR_W-1:0] ReadRegister2,
    input  logic [WIDTH-1:0]  ReadData1,
    input  logic [WIDTH-1:0]  ReadData2
);

    localparam logic [ADDR_W-1:0] AMAX     = '1;
    localparam logic [2:0]        PH_WR0   = 3'd1;
    localparam logic [2:0]        PH_RD0   = 3'd2;
    localparam logic [2:0]        PH_WEOFF = 3'd3;
    localparam logic [2:0]        PH_RD1   = 3'd4;
    localparam logic [2:0]        PH_WR1   = 3'd5;
    localparam logic [2:0]        PH_RD2   = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [2:0]        ph_p0, ph_nxt;
    logic [ADDR_W-1:0] addr_p0, addr_nxt;
    logic [1:0]        mism;
    logic              last_step;

    logic              busy_nxt, done_nxt, passed_nxt, wen_nxt;
    logic [2:0]        fphase_nxt;
    logic [ADDR_W-1:0] faddr_nxt, wreg_nxt, rreg1_nxt, rreg2_nxt;
    logic [1:0]        fport_nxt;
    logic [WIDTH-1:0]  wdata_nxt;

    // P(a): the address replicated across the word, then masked with the seed.
    function automatic logic [WIDTH-1:0] pat(input logic [ADDR_W-1:0] a);
        logic [WIDTH-1:0] p;
        p = '0;
        for (int i = 0; i < WIDTH; i++) begin
            p[i] = a[i % ADDR_W];
            if (i < 32) p[i] = p[i] ^ SEED[i];
        end
        return p;
    endfunction

    function automatic logic [WIDTH-1:0] expect_val(input logic [WIDTH-1:0] x,
                                                    input logic [ADDR_W-1:0] a);
        return ((ZERO_REG != 0) && (a == '0)) ? '0 : x;
    endfunction

    function automatic logic is_read(input logic [2:0] ph);
        return (ph == PH_RD0) || (ph == PH_RD1) || (ph == PH_RD2);
    endfunction

    function automatic logic is_wport(input logic [2:0] ph);
        return (ph == PH_WR0) || (ph == PH_WEOFF) || (ph == PH_WR1);
    endfunction

    // Contents the array should hold when read in phase ph.
    function automatic logic [WIDTH-1:0] read_pattern(input logic [2:0] ph,
                                                      input logic [ADDR_W-1:0] a);
        return (ph == PH_RD2) ? ~pat(a) : pat(a);
    endfunction

    // Compare stage: the reads presented after the previous edge are judged here.
    always_comb begin
        mism = 2'b00;
        if ((state == S_RUN) && is_read(ph_p0)) begin
            mism[0] = (ReadData1 !== expect_val(read_pattern(ph_p0, addr_p0), addr_p0));
            mism[1] = (ReadData2 !== expect_val(read_pattern(ph_p0, ~addr_p0), ~addr_p0));
        end
    end

    assign last_step = (ph_p0 == PH_RD2) && (addr_p0 == AMAX);

    always_comb begin
        state_nxt = state;
        ph_nxt    = ph_p0;
        addr_nxt  = addr_p0;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (Start) begin
                    state_nxt = S_RUN;
                    ph_nxt    = PH_WR0;
                    addr_nxt  = '0;
                end
            end
            S_RUN: begin
                if ((mism != 2'b00) || last_step) begin
                    state_nxt = S_DONE;
                end else begin
                    if (addr_p0 == AMAX) ph_nxt = ph_p0 + 3'd1;
                    addr_nxt = addr_p0 + 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Next values of every registered output; the write port is parked at r0 during reads.
    always_comb begin
        busy_nxt   = (state_nxt == S_RUN);
        done_nxt   = (state_nxt == S_DONE);
        wen_nxt    = busy_nxt && ((ph_nxt == PH_WR0) || (ph_nxt == PH_WR1));
        wreg_nxt   = '0;
        wdata_nxt  = '0;
        rreg1_nxt  = '0;
        rreg2_nxt  = '0;
        passed_nxt = Passed;
        fphase_nxt = FailPhase;
        faddr_nxt  = FailAddr;
        fport_nxt  = FailPort;
        if (busy_nxt) begin
            rreg1_nxt = addr_nxt;
            rreg2_nxt = ~addr_nxt;
            if (is_wport(ph_nxt)) begin
                wreg_nxt  = addr_nxt;
                wdata_nxt = (ph_nxt == PH_WR0) ? pat(addr_nxt) : ~pat(addr_nxt);
            end
        end
        if ((state != S_RUN) && busy_nxt) begin
            passed_nxt = 1'b0;
            fphase_nxt = '0;
            faddr_nxt  = '0;
            fport_nxt  = '0;
        end else if ((state == S_RUN) && done_nxt) begin
            if (mism != 2'b00) begin
                passed_nxt = 1'b0;
                fphase_nxt = ph_p0;
                faddr_nxt  = addr_p0;
                fport_nxt  = mism;
            end else begin
                passed_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state         <= S_IDLE;
            ph_p0         <= '0;
            addr_p0       <= '0;
            Busy          <= 1'b0;
            Done          <= 1'b0;
            Passed        <= 1'b0;
            FailPhase     <= '0;
            FailAddr      <= '0;
            FailPort      <= '0;
            WriteData     <= '0;
            WriteRegister <= '0;
            RegWrite      <= 1'b0;
            ReadRegister1 <= '0;
            ReadRegister2 <= '0;
        end else begin
            state         <= state_nxt;
            ph_p0         <= ph_nxt;
            addr_p0       <= addr_nxt;
            Busy          <= busy_nxt;
            Done          <= done_nxt;
            Passed        <= passed_nxt;
            FailPhase     <= fphase_nxt;
            FailAddr      <= faddr_nxt;
            FailPort      <= fport_nxt;
            WriteData     <= wdata_nxt;
            WriteRegister <= wreg_nxt;
            RegWrite      <= wen_nxt;
            ReadRegister1 <= rreg1_nxt;
            ReadRegister2 <= rreg2_nxt;
        end
    end

endmodule

// File: tb/tb_regfile_bist.sv
// Bench for regfile_bist: a faultable register file plus an array-based march model.
`timescale 1ns/1ps
module tb_regfile_bist;

    localparam int          WIDTH  = 32;
    localparam int          ADDR_W = 5;
    localparam int          DEPTH  = 32;
    localparam logic [31:0] SEED   = 32'hA5A55A5A;

    logic              Clk, Reset_n, Start;
    logic              Busy, Done, Passed, RegWrite;
    logic [2:0]        FailPhase;
    logic [ADDR_W-1:0] FailAddr, WriteRegister, ReadRegister1, ReadRegister2;
    logic [1:0]        FailPort;
    logic [WIDTH-1:0]  WriteData, ReadData1, ReadData2;

    // 0 good, 1 write enable ignored, 2 decoder writes all, 3 r0 writable, 4 port 2 stuck on r17
    int                fault;
    logic              load_rf;
    logic [WIDTH-1:0]  rf     [DEPTH];
    logic [WIDTH-1:0]  init_v [DEPTH];
    int                vectors, miscompares;

    regfile_bist #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .SEED(SEED), .ZERO_REG(1)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start),
        .Busy(Busy), .Done(Done), .Passed(Passed),
        .FailPhase(FailPhase), .FailAddr(FailAddr), .FailPort(FailPort),
        .WriteData(WriteData), .WriteRegister(WriteRegister), .RegWrite(RegWrite),
        .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .ReadData1(ReadData1), .ReadData2(ReadData2)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (load_rf) begin
            for (int i = 0; i < DEPTH; i++) rf[i] <= init_v[i];
        end else begin
            case (fault)
                1: if (WriteRegister != '0) rf[WriteRegister] <= WriteData;
                2: if (RegWrite) for (int i = 1; i < DEPTH; i++) rf[i] <= WriteData;
                3: if (RegWrite) rf[WriteRegister] <= WriteData;
                default: if (RegWrite && WriteRegister != '0) rf[WriteRegister] <= WriteData;
            endcase
        end
    end

    always_comb begin
        ReadData1 = (ReadRegister1 == '0 && fault != 3) ? '0 : rf[ReadRegister1];
        if (fault == 4) ReadData2 = rf[17];
        else            ReadData2 = (ReadRegister2 == '0 && fault != 3) ? '0 : rf[ReadRegister2];
    end

    function automatic logic [31:0] pp(input int a);
        logic [4:0]  aa;
        logic [34:0] rep;
        aa  = a[4:0];
        rep = {7{aa}};
        return rep[31:0] ^ SEED;
    endfunction

    function automatic logic [31:0] ev(input logic [31:0] x, input int a);
        return (a == 0) ? 32'h0 : x;
    endfunction

    task automatic chk(input string run, input string what,
                       input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s/%s: observed %0h expected %0h", run, what, obs, exp);
        end
    endtask

    // Runs the march sequentially over an array with the chosen fault semantics.
    task automatic model_run(input int f, output int eph, output int eaddr,
                             output int eport, output int ecyc, output int ewc);
        logic [31:0] m [DEPTH];
        logic [31:0] d, e1, e2, r1, r2;
        int          step, b;
        bit          stop, en;
        for (int i = 0; i < DEPTH; i++) m[i] = init_v[i];
        eph = 0; eaddr = 0; eport = 0; ewc = 0; step = 0; stop = 0;
        for (int ph = 1; ph <= 6 && !stop; ph++) begin
            for (int a = 0; a < DEPTH && !stop; a++) begin
                step++;
                b = DEPTH - 1 - a;
                if (ph == 1 || ph == 3 || ph == 5) begin
                    d  = (ph == 1) ? pp(a) : ~pp(a);
                    en = (ph != 3);
                    if (en) ewc++;
                    case (f)
                        1: if (a != 0) m[a] = d;
                        2: if (en) for (int j = 1; j < DEPTH; j++) m[j] = d;
                        3: if (en) m[a] = d;
                        default: if (en && a != 0) m[a] = d;
                    endcase
                end else begin
                    e1 = ev((ph == 6) ? ~pp(a) : pp(a), a);
                    e2 = ev((ph == 6) ? ~pp(b) : pp(b), b);
                    r1 = (a == 0 && f != 3) ? 32'h0 : m[a];
                    if (f == 4) r2 = m[17];
                    else        r2 = (b == 0 && f != 3) ? 32'h0 : m[b];
                    if (r1 !== e1 || r2 !== e2) begin
                        eph   = ph;
                        eaddr = a;
                        eport = {30'd0, (r2 !== e2), (r1 !== e1)};
                        stop  = 1;
                    end
                end
            end
        end
        ecyc = step;
    endtask

    task automatic load_random();
        for (int i = 0; i < DEPTH; i++) init_v[i] = $urandom;
        load_rf = 1'b1;
        @(negedge Clk);
        load_rf = 1'b0;
    endtask

    task automatic do_run(input int f, input string run);
        int eph, eaddr, eport, ecyc, ewc, k, wc;
        fault = f;
        @(negedge Clk);
        load_random();
        model_run(f, eph, eaddr, eport, ecyc, ewc);
        repeat ($urandom_range(0, 4)) @(negedge Clk);
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        chk(run, "busy_rise", {Busy, Done, Passed}, 3'b100);
        chk(run, "fail_clear", {FailPhase, FailAddr, FailPort}, '0);
        chk(run, "first_write", {RegWrite, WriteRegister, WriteData}, {1'b1, 5'd0, pp(0)});
        k  = 0;
        wc = RegWrite ? 1 : 0;
        while (!Done && k < 400) begin
            @(negedge Clk);
            k++;
            if (RegWrite) wc++;
            Start = Busy && ($urandom_range(0, 19) == 0);
        end
        Start = 1'b0;
        chk(run, "done_seen", Done, 1'b1);
        chk(run, "cycles", k, ecyc);
        chk(run, "passed", Passed, (eph == 0));
        chk(run, "fail_info", {FailPhase, FailAddr, FailPort}, {eph[2:0], eaddr[4:0], eport[1:0]});
        chk(run, "regwrite_cycles", wc, ewc);
        chk(run, "idle_outputs", {Busy, RegWrite}, 2'b00);
        repeat (3) @(negedge Clk);
        chk(run, "done_held", {Done, Passed}, {1'b1, (eph == 0)});
    endtask

    initial begin
        int wc;
        vectors = 0; miscompares = 0;
        fault = 0; load_rf = 1'b0; Start = 1'b0; Reset_n = 1'b0;
        for (int i = 0; i < DEPTH; i++) init_v[i] = '0;
        repeat (3) @(negedge Clk);
        chk("reset", "status", {Busy, Done, Passed, FailPhase, FailAddr, FailPort}, '0);
        chk("reset", "dut_ports", {RegWrite, WriteRegister, ReadRegister1, ReadRegister2, WriteData}, '0);
        Reset_n = 1'b1;
        @(negedge Clk);

        do_run(0, "clean");
        do_run(1, "we_ignored");
        do_run(2, "decode_all");
        do_run(3, "r0_writable");
        do_run(4, "port2_stuck");
        do_run(0, "rerun");

        // Abort in the middle of the first read phase.
        fault = 0;
        load_random();
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        repeat (32 + $urandom_range(1, 28)) @(negedge Clk);
        chk("abort", "busy_before", Busy, 1'b1);
        Reset_n = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
        chk("abort", "status", {Busy, Done, Passed, FailPhase, FailAddr, FailPort}, '0);
        chk("abort", "dut_ports", {RegWrite, WriteRegister, ReadRegister1, ReadRegister2, WriteData}, '0);
        wc = 0;
        repeat (6) begin
            @(negedge Clk);
            if (RegWrite || Busy) wc++;
        end
        chk("abort", "quiet_after", wc, 0);
        do_run(0, "after_abort");

        for (int r = 0; r < 3; r++) do_run($urandom_range(0, 4), "random");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
